// File: rtl/tap_loader.sv
// tap_loader: Oric TAP image parser and RAM loader.
// Walks sync/header/name blocks of a TAP byte stream and copies the selected
// file bodies (or every body) into RAM through a one-entry write register.
// Optional feature: define TAP_LOADER_CHECKSUM_EN to add the `checksum` port.
module tap_loader #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MAX_FILES   = 16,
  parameter logic [15:0] AUTORUN_MIN = 16'h0505,
  localparam int unsigned FSEL_W     = $clog2(MAX_FILES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              all_files,
  input  logic [FSEL_W-1:0] file_sel,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] loadpoint,
  output logic [ADDR_W-1:0] end_addr,
  output logic [7:0]        file_type,
  output logic              autorun_req,
  output logic [FSEL_W:0]   files_seen
`ifdef TAP_LOADER_CHECKSUM_EN
  , output logic [7:0]      checksum
`endif
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CMP_W = (ADDR_W > 16) ? ADDR_W : 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR, S_NAME, S_DATA, S_SKIP, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sync_cnt;
  logic [4:0]        r_idx;
  logic              r_all;
  logic [FSEL_W-1:0] r_sel;
  logic [FSEL_W:0]   r_files_seen;
  logic              r_sel_done;
  logic [15:0]       r_lp16;
  logic [15:0]       r_end16;
  logic [7:0]        r_type;
  logic [7:0]        r_arun_byte;
  logic [LEN_W-1:0]  r_remain;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err_code;
  logic              r_autorun;
  logic [7:0]        r_checksum;

  logic              w_s_ready;
  logic              w_fire;
  logic              w_drain_ok;
  logic              w_hit_max;
  logic              w_selected;
  logic [ADDR_W-1:0] w_lp;
  logic [ADDR_W-1:0] w_end;
  logic [LEN_W-1:0]  w_len;

  assign w_lp       = ADDR_W'(r_lp16);
  assign w_end      = ADDR_W'(r_end16);
  assign w_len      = LEN_W'(w_end) - LEN_W'(w_lp) + LEN_W'(1);
  assign w_drain_ok = !r_mem_wr || mem_ready;
  assign w_fire     = s_valid && w_s_ready;
  assign w_hit_max  = (r_files_seen == (FSEL_W+1)'(MAX_FILES));
  assign w_selected = r_all ||
                      ((FSEL_W+1)'(r_files_seen - (FSEL_W+1)'(1)) == (FSEL_W+1)'(r_sel));

  // Stream acceptance: free-running in parse states, gated by the write register in DATA.
  always_comb begin
    w_s_ready = 1'b0;
    case (r_state)
      S_SYNC, S_HDR, S_NAME, S_SKIP: w_s_ready = 1'b1;
      S_DATA:                        w_s_ready = (r_remain != '0) && w_drain_ok;
      default:                       w_s_ready = 1'b0;
    endcase
  end

  // Parser FSM with the write register and all status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sync_cnt   <= '0;
      r_idx        <= '0;
      r_all        <= 1'b0;
      r_sel        <= '0;
      r_files_seen <= '0;
      r_sel_done   <= 1'b0;
      r_lp16       <= '0;
      r_end16      <= '0;
      r_type       <= '0;
      r_arun_byte  <= '0;
      r_remain     <= '0;
      r_wr_addr    <= '0;
      r_mem_addr   <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= '0;
      r_autorun    <= 1'b0;
      r_checksum   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_mem_wr && mem_ready) r_mem_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_err_code   <= '0;
            r_files_seen <= '0;
            r_sync_cnt   <= '0;
            r_sel_done   <= 1'b0;
            r_autorun    <= 1'b0;
            r_checksum   <= '0;
            r_all        <= all_files;
            r_sel        <= file_sel;
            r_state      <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_fire) begin
            if (s_last) begin
              if (!r_sel_done) begin
                r_error    <= 1'b1;
                r_err_code <= 2'd1;
                r_state    <= S_ERR;
              end else if (w_drain_ok) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_remain <= '0;
                r_state  <= S_DATA;
              end
            end else if (s_data == 8'h24 && r_sync_cnt == 2'd3) begin
              r_sync_cnt <= '0;
              r_idx      <= '0;
              r_state    <= S_HDR;
            end else if (s_data == 8'h16) begin
              r_sync_cnt <= (r_sync_cnt == 2'd3) ? 2'd3 : r_sync_cnt + 2'd1;
            end else begin
              r_sync_cnt <= '0;
            end
          end
        end
        S_HDR: begin
          if (w_fire) begin
            if (s_last) begin
              r_error    <= 1'b1;
              r_err_code <= 2'd3;
              r_state    <= S_ERR;
            end else begin
              case (r_idx)
                5'd2:    r_type        <= s_data;
                5'd3:    r_arun_byte   <= s_data;
                5'd4:    r_end16[15:8] <= s_data;
                5'd5:    r_end16[7:0]  <= s_data;
                5'd6:    r_lp16[15:8]  <= s_data;
                5'd7:    r_lp16[7:0]   <= s_data;
                default: ;
              endcase
              r_idx <= r_idx + 5'd1;
              if (r_idx == 5'd8) begin
                r_idx <= '0;
                if (w_end < w_lp) begin
                  r_error    <= 1'b1;
                  r_err_code <= 2'd2;
                  r_state    <= S_ERR;
                end else begin
                  r_files_seen <= r_files_seen + (FSEL_W+1)'(1);
                  r_autorun    <= (r_arun_byte != 8'h00) ||
                                  (CMP_W'(w_lp) > CMP_W'(AUTORUN_MIN));
                  r_state      <= S_NAME;
                end
              end
            end
          end
        end
        S_NAME: begin
          if (w_fire) begin
            if (s_last) begin
              r_error    <= 1'b1;
              r_err_code <= 2'd3;
              r_state    <= S_ERR;
            end else if (s_data == 8'h00) begin
              r_remain  <= w_len;
              r_wr_addr <= w_lp;
              r_state   <= w_selected ? S_DATA : S_SKIP;
            end else if (r_idx == 5'd16) begin
              r_error    <= 1'b1;
              r_err_code <= 2'd2;
              r_state    <= S_ERR;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (r_remain == '0) begin
            // Final byte taken; wait for the RAM to accept it before completing.
            if (w_drain_ok) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_fire) begin
            r_mem_wr   <= 1'b1;
            r_mem_addr <= r_wr_addr;
            r_mem_dout <= s_data;
            r_checksum <= r_checksum + s_data;
            r_wr_addr  <= r_wr_addr + ADDR_W'(1);
            r_remain   <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) begin
              r_sel_done <= 1'b1;
              if (r_all && !w_hit_max && !s_last) begin
                r_sync_cnt <= '0;
                r_state    <= S_SYNC;
              end
            end else if (s_last) begin
              r_error    <= 1'b1;
              r_err_code <= 2'd3;
              r_state    <= S_ERR;
            end
          end
        end
        S_SKIP: begin
          if (w_fire) begin
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) begin
              if (s_last || w_hit_max) begin
                if (r_sel_done) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_error    <= 1'b1;
                  r_err_code <= 2'd1;
                  r_state    <= S_ERR;
                end
              end else begin
                r_sync_cnt <= '0;
                r_state    <= S_SYNC;
              end
            end else if (s_last) begin
              r_error    <= 1'b1;
              r_err_code <= 2'd3;
              r_state    <= S_ERR;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready     = w_s_ready;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_dout    = r_mem_dout;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign loadpoint   = w_lp;
  assign end_addr    = w_end;
  assign file_type   = r_type;
  assign autorun_req = r_autorun;
  assign files_seen  = r_files_seen;
`ifdef TAP_LOADER_CHECKSUM_EN
  assign checksum    = r_checksum;
`else
  logic w_unused_checksum;
  assign w_unused_checksum = ^r_checksum;
`endif

endmodule

// File: tb/tb_tap_loader.sv
// tb_tap_loader: directed bench for tap_loader with a write scoreboard.
module tb_tap_loader;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned FSEL_W = 4;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              all_files;
  logic [FSEL_W-1:0] file_sel;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic              mem_wr;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] loadpoint;
  logic [ADDR_W-1:0] end_addr;
  logic [7:0]        file_type;
  logic              autorun_req;
  logic [FSEL_W:0]   files_seen;
`ifdef TAP_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  tap_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .all_files(all_files),
    .file_sel(file_sel), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .mem_wr(mem_wr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .loadpoint(loadpoint), .end_addr(end_addr),
    .file_type(file_type), .autorun_req(autorun_req), .files_seen(files_seen)
`ifdef TAP_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  bit          rdy_toggle = 0;
  logic [7:0]  img[$];
  logic [23:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM side: random back-pressure when enabled.
  always @(negedge clk) mem_ready = rdy_toggle ? 1'($urandom_range(0, 1)) : 1'b1;

  // Monitor: pops the scoreboard on each write handshake and checks hold stability.
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] h_addr;
  logic [7:0]        h_data;
  always begin
    logic [23:0] e;
    @(negedge clk); #4;
    if (done) done_cnt++;
    if (hold && reset_n) begin
      chk("hold_wr", 32'(mem_wr), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'(h_addr));
      chk("hold_data", 32'(mem_dout), 32'(h_data));
    end
    hold   = mem_wr && !mem_ready;
    h_addr = mem_addr;
    h_data = mem_dout;
    if (mem_wr && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[23:8]));
        chk("wr_data", 32'(mem_dout), 32'(e[7:0]));
      end
    end
  end

  task automatic new_test();
    img.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic add_file(input logic [7:0] typ, input logic [7:0] arun,
                          input logic [15:0] lp, input logic [15:0] ea,
                          input int nbytes, input bit expect_wr);
    logic [7:0] d;
    repeat (3) img.push_back(8'h16);
    img.push_back(8'h24);
    img.push_back(8'h00); img.push_back(8'h00);
    img.push_back(typ);   img.push_back(arun);
    img.push_back(ea[15:8]); img.push_back(ea[7:0]);
    img.push_back(lp[15:8]); img.push_back(lp[7:0]);
    img.push_back(8'h00);
    img.push_back(8'h41); img.push_back(8'h00);
    for (int i = 0; i < nbytes; i++) begin
      d = 8'($urandom);
      img.push_back(d);
      if (expect_wr) exp_q.push_back({lp + 16'(i), d});
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    #4;
    while (!s_ready && n < 200) begin
      @(negedge clk); #4; n++;
    end
    chk("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_img(input int n, input bit mark_last);
    for (int i = 0; i < n; i++) send(img[i], mark_last && (i == n - 1));
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_start(input bit all, input logic [FSEL_W-1:0] sel);
    @(negedge clk);
    all_files = all; file_sel = sel; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_end();
    bit ended = 0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      @(negedge clk); #4;
      if (done_cnt > 0 || error) ended = 1;
    end
    chk("end_timeout", 32'(ended), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_ok(input string t, input int nfiles, input logic [15:0] lp,
                          input logic [15:0] ea, input logic [7:0] typ, input bit ar);
    chk({t, "_done"}, 32'(done_cnt), 32'd1);
    chk({t, "_error"}, 32'(error), 32'd0);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_files"}, 32'(files_seen), 32'(nfiles));
    chk({t, "_loadpoint"}, 32'(loadpoint), 32'(lp));
    chk({t, "_end"}, 32'(end_addr), 32'(ea));
    chk({t, "_type"}, 32'(file_type), 32'(typ));
    chk({t, "_autorun"}, 32'(autorun_req), 32'(ar));
    chk({t, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_err(input string t, input logic [1:0] code);
    chk({t, "_error"}, 32'(error), 32'd1);
    chk({t, "_code"}, 32'(err_code), 32'(code));
    chk({t, "_done"}, 32'(done_cnt), 32'd0);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; all_files = 1'b0; file_sel = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_files", 32'(files_seen), 32'd0);
    chk("rst_loadpoint", 32'(loadpoint), 32'd0);
    chk("rst_autorun", 32'(autorun_req), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single BASIC file, 3 bytes at 0x0501.
    new_test();
    add_file(8'h00, 8'h00, 16'h0501, 16'h0503, 3, 1);
    do_start(1'b0, 4'd0);
    send_img(img.size(), 1'b1); idle();
    wait_end();
    check_ok("basic", 1, 16'h0501, 16'h0503, 8'h00, 1'b0);

    // Code file with autorun byte and toggling mem_ready.
    new_test();
    rdy_toggle = 1;
    add_file(8'h80, 8'hC7, 16'h9800, 16'h980F, 16, 1);
    do_start(1'b0, 4'd0);
    send_img(img.size(), 1'b1); idle();
    wait_end();
    check_ok("code", 1, 16'h9800, 16'h980F, 8'h80, 1'b1);
    rdy_toggle = 0;

    // Two files, select file 1 only.
    new_test();
    add_file(8'h00, 8'h00, 16'h0600, 16'h0602, 3, 0);
    add_file(8'h80, 8'h00, 16'h0700, 16'h0703, 4, 1);
    do_start(1'b0, 4'd1);
    send_img(img.size(), 1'b1); idle();
    wait_end();
    check_ok("sel1", 2, 16'h0700, 16'h0703, 8'h80, 1'b1);

    // Two files, load all, with back-pressure.
    new_test();
    rdy_toggle = 1;
    add_file(8'h80, 8'h00, 16'h0400, 16'h0404, 5, 1);
    add_file(8'h00, 8'h00, 16'h0480, 16'h0482, 3, 1);
    do_start(1'b1, 4'd0);
    send_img(img.size(), 1'b1); idle();
    wait_end();
    check_ok("all", 2, 16'h0480, 16'h0482, 8'h00, 1'b0);
    rdy_toggle = 0;

    // s_last after 2 of 4 data bytes.
    new_test();
    add_file(8'h00, 8'h00, 16'h0800, 16'h0803, 4, 1);
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    do_start(1'b0, 4'd0);
    send_img(img.size() - 2, 1'b1); idle();
    wait_end();
    check_err("trunc", 2'd3);

    // Header end below start: stop sending after header byte 8.
    new_test();
    add_file(8'h00, 8'h00, 16'h0500, 16'h0400, 0, 0);
    do_start(1'b0, 4'd0);
    send_img(13, 1'b0); idle();
    wait_end();
    check_err("badhdr", 2'd2);

    // No 0x24 marker anywhere.
    new_test();
    img.push_back(8'h16); img.push_back(8'h16); img.push_back(8'h16);
    img.push_back(8'h55); img.push_back(8'h16); img.push_back(8'h00);
    do_start(1'b0, 4'd0);
    send_img(img.size(), 1'b1); idle();
    wait_end();
    check_err("nofile", 2'd1);

    // Reset asserted mid-DATA with a write in flight.
    new_test();
    add_file(8'h00, 8'h00, 16'h0900, 16'h090F, 16, 1);
    do_start(1'b0, 4'd0);
    send_img(20, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_loadpoint", 32'(loadpoint), 32'd0);
    chk("midrst_files", 32'(files_seen), 32'd0);
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clk);

    // Clean parse after the aborted one.
    new_test();
    add_file(8'h80, 8'h00, 16'h0A00, 16'h0A05, 6, 1);
    do_start(1'b0, 4'd0);
    send_img(img.size(), 1'b1); idle();
    wait_end();
    check_ok("after_rst", 1, 16'h0A00, 16'h0A05, 8'h80, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
